// File: rtl/pla_onset_extractor_if.sv
// Bus bundle for pla_onset_extractor: sweep control, function drive/sample
// and the minterm valid/ready stream. Optional polarity input exists only
// when PLA_OFFSET_EXTRACT_EN is defined.
interface pla_onset_extractor_if #(
    parameter int N_IN = 15
);
    logic            start;
    logic [N_IN-1:0] x_out;
    logic            y_in;
    logic            busy;
    logic            done;
    logic            m_valid;
    logic            m_ready;
    logic [N_IN-1:0] m_data;
    logic [N_IN:0]   onset_count;
`ifdef PLA_OFFSET_EXTRACT_EN
    logic            polarity;

    // extractor side
    modport master (
        input  start, y_in, m_ready, polarity,
        output x_out, busy, done, m_valid, m_data, onset_count
    );
    // function-under-test / consumer side
    modport slave (
        output start, y_in, m_ready, polarity,
        input  x_out, busy, done, m_valid, m_data, onset_count
    );
`else
    // extractor side
    modport master (
        input  start, y_in, m_ready,
        output x_out, busy, done, m_valid, m_data, onset_count
    );
    // function-under-test / consumer side
    modport slave (
        output start, y_in, m_ready,
        input  x_out, busy, done, m_valid, m_data, onset_count
    );
`endif
endinterface

// File: rtl/pla_onset_extractor.sv
// pla_onset_extractor: walks x_out through every input vector in ascending
// order, waits EVAL_LAT cycles for the function output to settle, and
// streams each vector whose output equals the target as a minterm.
// Optional feature macro: PLA_OFFSET_EXTRACT_EN (adds polarity input; the
// target value is latched from it on the accepted start).
module pla_onset_extractor #(
    parameter int N_IN     = 15,
    parameter int EVAL_LAT = 0
) (
    input logic                    clk,
    input logic                    rst,
    pla_onset_extractor_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EMIT, S_DONE} state_t;

    localparam logic [3:0]      LAT     = 4'(EVAL_LAT);
    localparam logic [3:0]      SET_ONE = 4'd1;
    localparam logic [N_IN-1:0] X_ONE   = 1;
    localparam logic [N_IN:0]   CNT_ONE = 1;

    state_t          state_q, state_d;
    logic [N_IN-1:0] x_q, x_d;
    logic [N_IN-1:0] data_q, data_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic [3:0]      settle_q, settle_d;
    logic            tgt_q, tgt_d;
    logic            adv;

    // State register: all sweep state, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            tgt_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            tgt_q    <= tgt_d;
        end
    end

    // Next-state: settle countdown, hit/miss decision and vector advance
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        tgt_d    = tgt_q;
        adv      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d      = '0;
                    settle_d = LAT;
                    cnt_d    = '0;
`ifdef PLA_OFFSET_EXTRACT_EN
                    tgt_d    = bus.polarity;
`else
                    tgt_d    = 1'b1;
`endif
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q != 4'd0) begin
                    settle_d = settle_q - SET_ONE;
                end else if (bus.y_in == tgt_q) begin
                    data_d  = x_q;
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = S_EMIT;
                end else begin
                    adv = 1'b1;
                end
            end
            S_EMIT: begin
                if (bus.m_ready) adv = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Advance shares the edge with the miss / handshake that caused it
        if (adv) begin
            if (&x_q) begin
                state_d = S_DONE;
            end else begin
                x_d      = x_q + X_ONE;
                settle_d = LAT;
                state_d  = S_SETTLE;
            end
        end
    end

    // Outputs: status decoded from state, data straight from registers
    always_comb begin
        bus.busy        = (state_q == S_SETTLE) || (state_q == S_EMIT);
        bus.done        = (state_q == S_DONE);
        bus.m_valid     = (state_q == S_EMIT);
        bus.x_out       = x_q;
        bus.m_data      = data_q;
        bus.onset_count = cnt_q;
    end
endmodule

// File: tb/tb_pla_onset_extractor.sv
// Bench for pla_onset_extractor: two instances (4-input combinational
// function, 5-input function behind a 2-register delay with EVAL_LAT=2)
// swept with random truth tables and random consumer back-pressure,
// checked against an expected ascending minterm list built from the table.
module tb_pla_onset_extractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pla_onset_extractor_if #(.N_IN(4)) if0 ();
    pla_onset_extractor_if #(.N_IN(5)) if1 ();

    pla_onset_extractor #(.N_IN(4), .EVAL_LAT(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    pla_onset_extractor #(.N_IN(5), .EVAL_LAT(2)) u1 (.clk(clk), .rst(rst), .bus(if1));

    // functions under extraction
    logic [31:0] tt0 = '0, tt1 = '0;
    logic        d1 = 1'b0, d2 = 1'b0;
    assign if0.y_in = tt0[if0.x_out];
    always @(posedge clk) begin
        d1 <= tt1[if1.x_out];
        d2 <= d1;
    end
    assign if1.y_in = d2;

    int total = 0, bad = 0;
    int pct = 100;
    bit mon_en = 1'b0;

    // scoreboard state per instance
    int exp_list [2][32];
    int exp_n [2], ptr [2], busy_cyc [2], vld_cyc [2], done_cnt [2];
    int prev_md [2], prev_xo [2];
    bit prev_stall [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mon(input int d, input int n, input int lat, input logic bsy, input logic dn,
                       input logic mv, input logic mr, input int xo, input int md, input int cnt);
        if (prev_stall[d]) begin
            chk($sformatf("u%0d_stall_valid", d), mv, 1);
            chk($sformatf("u%0d_stall_data", d), md, prev_md[d]);
            chk($sformatf("u%0d_stall_xout", d), xo, prev_xo[d]);
        end
        if (mv) begin
            vld_cyc[d]++;
            chk($sformatf("u%0d_xout_eq_mdata", d), xo, md);
        end
        if (mv && mr) begin
            chk($sformatf("u%0d_minterm", d), md, (ptr[d] < exp_n[d]) ? exp_list[d][ptr[d]] : -1);
            ptr[d]++;
        end
        if (bsy) busy_cyc[d]++;
        if (dn) begin
            done_cnt[d]++;
            chk($sformatf("u%0d_onset_count", d), cnt, exp_n[d]);
            chk($sformatf("u%0d_emitted_all", d), ptr[d], exp_n[d]);
            chk($sformatf("u%0d_sweep_cycles", d), busy_cyc[d], (1 << n) * (lat + 1) + vld_cyc[d]);
            chk($sformatf("u%0d_busy_at_done", d), bsy, 0);
        end
        prev_stall[d] = mv && !mr;
        prev_md[d]    = md;
        prev_xo[d]    = xo;
    endtask

    task automatic step();
        @(negedge clk);
        if0.m_ready = ($urandom_range(0, 99) < pct);
        if1.m_ready = ($urandom_range(0, 99) < pct);
`ifdef PLA_OFFSET_EXTRACT_EN
        if0.polarity = 1'($urandom);
        if1.polarity = 1'($urandom);
`endif
        if (mon_en) begin
            mon(0, 4, 0, if0.busy, if0.done, if0.m_valid, if0.m_ready, int'(if0.x_out), int'(if0.m_data), int'(if0.onset_count));
            mon(1, 5, 2, if1.busy, if1.done, if1.m_valid, if1.m_ready, int'(if1.x_out), int'(if1.m_data), int'(if1.onset_count));
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_u0_xout"}, if0.x_out, 0);
        chk({tag, "_u0_busy"}, if0.busy, 0);
        chk({tag, "_u0_done"}, if0.done, 0);
        chk({tag, "_u0_mvalid"}, if0.m_valid, 0);
        chk({tag, "_u0_mdata"}, if0.m_data, 0);
        chk({tag, "_u0_count"}, if0.onset_count, 0);
        chk({tag, "_u1_xout"}, if1.x_out, 0);
        chk({tag, "_u1_busy"}, if1.busy, 0);
        chk({tag, "_u1_mvalid"}, if1.m_valid, 0);
        chk({tag, "_u1_count"}, if1.onset_count, 0);
    endtask

    // One sweep of both instances; tables a/b, target polarity, ready percentage
    task automatic run_sweep(input logic [31:0] a, input logic [31:0] b, input logic pol,
                             input int rdy, input bit mid_start);
        logic tgt;
        bit pend0, pend1;
        int c;
`ifdef PLA_OFFSET_EXTRACT_EN
        tgt = pol;
`else
        tgt = 1'b1;
`endif
        tt0 = a;
        tt1 = b;
        for (int d = 0; d < 2; d++) begin
            exp_n[d] = 0; ptr[d] = 0; busy_cyc[d] = 0; vld_cyc[d] = 0;
            done_cnt[d] = 0; prev_stall[d] = 1'b0;
        end
        for (int i = 0; i < 16; i++)
            if (a[i] == tgt) begin exp_list[0][exp_n[0]] = i; exp_n[0]++; end
        for (int i = 0; i < 32; i++)
            if (b[i] == tgt) begin exp_list[1][exp_n[1]] = i; exp_n[1]++; end
        pct = rdy;
        pend0 = 1'b0;
        pend1 = 1'b0;
        step();
        if0.start = 1'b1;
        if1.start = 1'b1;
`ifdef PLA_OFFSET_EXTRACT_EN
        if0.polarity = pol;
        if1.polarity = pol;
`endif
        c = 0;
        while (c < 4000 && !(done_cnt[0] > 0 && done_cnt[1] > 0)) begin
            step();
            c++;
            if0.start = 1'b0;
            if1.start = 1'b0;
            if (pend0) begin chk("u0_start_in_done", if0.busy, 0); pend0 = 1'b0; end
            if (pend1) begin chk("u1_start_in_done", if1.busy, 0); pend1 = 1'b0; end
            if (if0.done && if1.busy) begin
                if0.start = 1'b1; if1.start = 1'b1; pend0 = 1'b1;
            end else if (if1.done && if0.busy) begin
                if0.start = 1'b1; if1.start = 1'b1; pend1 = 1'b1;
            end else if (mid_start && if0.busy && if1.busy && $urandom_range(0, 19) == 0) begin
                if0.start = 1'b1; if1.start = 1'b1;
            end
        end
        if (c >= 4000) chk("sweep_timeout", 0, 1);
        step();
        if0.start = 1'b0;
        if1.start = 1'b0;
        step();
        chk("u0_done_pulses", done_cnt[0], 1);
        chk("u1_done_pulses", done_cnt[1], 1);
        chk("u0_idle_after", if0.busy, 0);
        chk("u1_idle_after", if1.busy, 0);
    endtask

    initial begin
        int c;
        if0.start = 1'b0; if1.start = 1'b0;
        if0.m_ready = 1'b0; if1.m_ready = 1'b0;
`ifdef PLA_OFFSET_EXTRACT_EN
        if0.polarity = 1'b1; if1.polarity = 1'b1;
`endif
        repeat (3) step();
        chk_rst("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // x0&x1 -> 3,7,11,15 ; single vector 5 through the delayed function
        run_sweep(32'h0000_8888, 32'h0000_0020, 1'b1, 100, 1'b0);
        // empty function, and the same with back-pressure
        run_sweep(32'h0, 32'h0, 1'b1, 100, 1'b0);
        run_sweep(32'h0000_8888, 32'h0000_0020, 1'b1, 30, 1'b0);
        // constant 1: count reaches 2^N without wrap
        run_sweep(32'h0000_FFFF, 32'hFFFF_FFFF, 1'b1, 100, 1'b1);
`ifdef PLA_OFFSET_EXTRACT_EN
        // OFF-set of x2 on the 4-input instance -> 0..3 and 8..11
        run_sweep(32'h0000_F0F0, 32'hF0F0_F0F0, 1'b0, 100, 1'b1);
`endif
        for (int r = 0; r < 8; r++)
            run_sweep($urandom, $urandom, 1'($urandom), $urandom_range(20, 100), 1'b1);

        // reset while a minterm is pending
        mon_en = 1'b0;
        tt0 = 32'h0000_FFFF;
        tt1 = 32'hFFFF_FFFF;
        pct = 0;
        step();
        if0.start = 1'b1; if1.start = 1'b1;
`ifdef PLA_OFFSET_EXTRACT_EN
        if0.polarity = 1'b1; if1.polarity = 1'b1;
`endif
        c = 0;
        do begin
            step();
            if0.start = 1'b0; if1.start = 1'b0;
            c++;
        end while (c < 50 && !(if0.m_valid && if1.m_valid));
        chk("pre_rst_valid", {if0.m_valid, if1.m_valid}, 2'b11);
        chk("pre_rst_count", if1.onset_count, 1);
        rst = 1'b1;
        step();
        chk_rst("mid_rst");
        rst = 1'b0;
        mon_en = 1'b1;
        run_sweep($urandom, $urandom, 1'b1, 60, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
